// File: rtl/dif_radix2_tm_param.sv
// Radix-2 DIF twiddle multiplier: multiplies each complex sample by W_N^k (or its
// conjugate) using a one-octant table, octant folding and quadrant rotation.
`timescale 1ns/1ps
module dif_radix2_tm_param #(
  parameter int    DATA_WIDTH_IN  = 10,
  parameter int    DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
  parameter int    TW_WIDTH       = 12,
  parameter int    LOG2N          = 6,
  parameter string TW_FILE        = "tw_rom.hex"
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH_IN-1:0]  din_real,
  input  logic [DATA_WIDTH_IN-1:0]  din_imag,
  input  logic [LOG2N-1:0]          tw_idx,
  input  logic                      inverse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH_OUT-1:0] dout_real,
  output logic [DATA_WIDTH_OUT-1:0] dout_imag,
  output logic                      out_sat
);

  localparam int N8 = 1 << (LOG2N - 3);
  localparam int RW = LOG2N - 2;
  localparam int PW = DATA_WIDTH_IN + TW_WIDTH;
  localparam int AW = PW + 2;
  localparam logic signed [AW-1:0] RND  = AW'(1) << (TW_WIDTH - 2);
  localparam logic signed [AW-1:0] OMAX = AW'((longint'(1) <<< (DATA_WIDTH_OUT - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  // Octant table {cos,sin} for m = 0..N/8, built at elaboration with a Q30 Taylor
  // series and rounded to nearest; it holds the same image TW_FILE would carry.
  function automatic logic [2*TW_WIDTH-1:0] tw_entry(input int m);
    longint x, x2, ct, st, c, s, one, cq, sq;
    x  = (longint'(m) * 64'sd6746518852) >>> LOG2N;
    x2 = (x * x) >>> 30;
    c  = 64'sd1073741824;
    ct = c;
    s  = x;
    st = x;
    for (int i = 1; i <= 7; i++) begin
      ct = -((ct * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      st = -((st * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      c  = c + ct;
      s  = s + st;
    end
    one = longint'(1) <<< (TW_WIDTH - 1);
    cq  = (c * one + (longint'(1) <<< 29)) >>> 30;
    sq  = (s * one + (longint'(1) <<< 29)) >>> 30;
    if (cq > one - 1) cq = one - 1;
    if (sq > one - 1) sq = one - 1;
    return {cq[TW_WIDTH-1:0], sq[TW_WIDTH-1:0]};
  endfunction

  function automatic logic [DATA_WIDTH_OUT:0] clip(input logic signed [AW-1:0] v);
    if (v > OMAX)      clip = {1'b1, OMAX[DATA_WIDTH_OUT-1:0]};
    else if (v < OMIN) clip = {1'b1, OMIN[DATA_WIDTH_OUT-1:0]};
    else               clip = {1'b0, v[DATA_WIDTH_OUT-1:0]};
  endfunction

  logic [2*TW_WIDTH-1:0] rom [N8+1];

  for (genvar g = 0; g <= N8; g++) begin : g_rom
    localparam logic [2*TW_WIDTH-1:0] ENTRY = tw_entry(g);
    assign rom[g] = ENTRY;
  end

  // Handshake: a sample moves on an edge where valid && ready; every stage
  // advances together whenever the output register is free or being drained.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // S1: index decode and table lookup
  logic [RW-1:0]         r;
  logic [RW-1:0]         addr;
  logic                  swap;
  logic [2*TW_WIDTH-1:0] rom_word;
  logic [TW_WIDTH-1:0]   c_in, s_in;

  always_comb begin
    r        = tw_idx[RW-1:0];
    swap     = (r > RW'(N8));
    addr     = swap ? (~r + 1'b1) : r;
    rom_word = rom[addr];
    c_in     = swap ? rom_word[TW_WIDTH-1:0] : rom_word[2*TW_WIDTH-1:TW_WIDTH];
    s_in     = swap ? rom_word[2*TW_WIDTH-1:TW_WIDTH] : rom_word[TW_WIDTH-1:0];
  end

  logic                             s1_valid, s1_inv, s1_triv;
  logic [1:0]                       s1_qd;
  logic signed [TW_WIDTH-1:0]       s1_c, s1_s;
  logic signed [DATA_WIDTH_IN-1:0]  s1_re, s1_im;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_triv  <= 1'b0;
      s1_qd    <= '0;
      s1_c     <= '0;
      s1_s     <= '0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_inv   <= inverse;
      s1_triv  <= (r == '0);
      s1_qd    <= tw_idx[LOG2N-1:LOG2N-2];
      s1_c     <= c_in;
      s1_s     <= s_in;
      s1_re    <= din_real;
      s1_im    <= din_imag;
    end
  end

  // S2: full-precision complex multiply; trivial twiddles bypass the table
  logic signed [PW-1:0] re_c, im_s, im_c, re_s;
  logic signed [AW-1:0] p_n, q_n;

  always_comb begin
    re_c = PW'(s1_re) * PW'(s1_c);
    im_s = PW'(s1_im) * PW'(s1_s);
    im_c = PW'(s1_im) * PW'(s1_c);
    re_s = PW'(s1_re) * PW'(s1_s);
    if (s1_triv) begin
      p_n = AW'(s1_re) <<< (TW_WIDTH - 1);
      q_n = AW'(s1_im) <<< (TW_WIDTH - 1);
    end else if (s1_inv) begin
      p_n = AW'(re_c) - AW'(im_s);
      q_n = AW'(im_c) + AW'(re_s);
    end else begin
      p_n = AW'(re_c) + AW'(im_s);
      q_n = AW'(im_c) - AW'(re_s);
    end
  end

  logic                 s2_valid, s2_inv;
  logic [1:0]           s2_qd;
  logic signed [AW-1:0] s2_p, s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inv   <= 1'b0;
      s2_qd    <= '0;
      s2_p     <= '0;
      s2_q     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_inv   <= s1_inv;
      s2_qd    <= s1_qd;
      s2_p     <= p_n;
      s2_q     <= q_n;
    end
  end

  // S3: the inverse rotation by (+j)^q equals the forward one by (-j)^(-q)
  logic [1:0]              qe;
  logic signed [AW-1:0]    rot_p, rot_q, rnd_p, rnd_q;
  logic [DATA_WIDTH_OUT:0] cr, ci;

  always_comb begin
    qe = s2_inv ? (2'd0 - s2_qd) : s2_qd;
    case (qe)
      2'd0:    begin rot_p = s2_p;  rot_q = s2_q;  end
      2'd1:    begin rot_p = s2_q;  rot_q = -s2_p; end
      2'd2:    begin rot_p = -s2_p; rot_q = -s2_q; end
      default: begin rot_p = -s2_q; rot_q = s2_p;  end
    endcase
    rnd_p = (rot_p + RND) >>> (TW_WIDTH - 1);
    rnd_q = (rot_q + RND) >>> (TW_WIDTH - 1);
    cr    = clip(rnd_p);
    ci    = clip(rnd_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      dout_real <= '0;
      dout_imag <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        dout_real <= cr[DATA_WIDTH_OUT-1:0];
        dout_imag <= ci[DATA_WIDTH_OUT-1:0];
        out_sat   <= cr[DATA_WIDTH_OUT] | ci[DATA_WIDTH_OUT];
      end
    end
  end

endmodule

// File: tb/tb_dif_radix2_tm_param.sv
// Self-checking bench for dif_radix2_tm_param: directed exact cases, a full twiddle
// sweep against a floating-point model, backpressure, reset flush and saturation.
`timescale 1ns/1ps
module tb_dif_radix2_tm_param;

  localparam int DWI   = 10;
  localparam int DWO   = 11;
  localparam int TW    = 12;
  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;
  localparam int W     = 2 * DWO + 1;
  localparam real PI   = 3.14159265358979323846;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    in_valid = 1'b0, in_ready, inverse = 1'b0;
  logic signed [DWI-1:0]   din_real = '0, din_imag = '0;
  logic [LOG2N-1:0]        tw_idx = '0;
  logic                    out_valid, out_ready = 1'b1, out_sat;
  logic signed [DWO-1:0]   dout_real, dout_imag;

  dif_radix2_tm_param #(.DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .TW_WIDTH(TW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din_real(din_real), .din_imag(din_imag), .tw_idx(tw_idx), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready), .dout_real(dout_real),
    .dout_imag(dout_imag), .out_sat(out_sat)
  );

  logic                  b_in_valid = 1'b0, b_in_ready, b_inverse = 1'b0;
  logic signed [DWI-1:0] b_din_real = '0, b_din_imag = '0;
  logic [LOG2N-1:0]      b_tw_idx = '0;
  logic                  b_out_valid, b_out_ready = 1'b1, b_out_sat;
  logic signed [9:0]     b_dout_real, b_dout_imag;

  dif_radix2_tm_param #(.DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(10), .TW_WIDTH(TW), .LOG2N(LOG2N)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .din_real(b_din_real), .din_imag(b_din_imag), .tw_idx(b_tw_idx), .inverse(b_inverse),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .dout_real(b_dout_real),
    .dout_imag(b_dout_imag), .out_sat(b_out_sat)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  real          ire_q[$], iim_q[$];
  int           tin_q[$];
  int           n_cmp = 0, n_bad = 0;
  int           cyc = 0;
  bit           lat_en = 1'b1, bp_mode = 1'b0, held = 1'b0;
  int           bp_cnt = 0;
  logic [W-1:0] held_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic ideal(input int re, input int im, input int k, input bit inv,
                       output real ir, output real ii);
    real th, cr, sr;
    th = 2.0 * PI * k / N;
    cr = $cos(th);
    sr = $sin(th);
    if (!inv) begin ir = re * cr + im * sr; ii = im * cr - re * sr; end
    else      begin ir = re * cr - im * sr; ii = im * cr + re * sr; end
  endtask

  // Integer model: twiddle rounded straight from the full-circle angle, then
  // round-half-up and clamp.
  function automatic logic [W-1:0] model(input int re, input int im, input int k, input bit inv);
    real th, one;
    longint tc, ts, p, q, orr, oi, lim;
    bit sat;
    th  = 2.0 * PI * k / N;
    one = real'(longint'(1) <<< (TW - 1));
    tc  = longint'($floor($cos(th) * one + 0.5));
    ts  = longint'($floor($sin(th) * one + 0.5));
    if (!inv) begin p = re * tc + im * ts; q = im * tc - re * ts; end
    else      begin p = re * tc - im * ts; q = im * tc + re * ts; end
    orr = (p + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
    oi  = (q + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
    lim = longint'(1) <<< (DWO - 1);
    sat = 1'b0;
    if (orr > lim - 1) begin orr = lim - 1; sat = 1'b1; end
    if (orr < -lim)    begin orr = -lim;    sat = 1'b1; end
    if (oi > lim - 1)  begin oi = lim - 1;  sat = 1'b1; end
    if (oi < -lim)     begin oi = -lim;     sat = 1'b1; end
    return {sat, DWO'(orr), DWO'(oi)};
  endfunction

  // driver: hold the sample until accepted; returns the accepting cycle
  task automatic drive(input int re, input int im, input int k, input bit inv,
                       output bit ok, output int t);
    int n;
    bit acc;
    din_real = DWI'(re);
    din_imag = DWI'(im);
    tw_idx   = k[LOG2N-1:0];
    inverse  = inv;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      t   = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    ok = acc;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic push(input logic [W-1:0] e, input int re, input int im, input int k,
                      input bit inv, input int t);
    real ir, ii;
    ideal(re, im, k, inv, ir, ii);
    exp_q.push_back(e);
    ire_q.push_back(ir);
    iim_q.push_back(ii);
    tin_q.push_back(t);
  endtask

  task automatic send_model(input int re, input int im, input int k, input bit inv);
    bit ok;
    int t;
    drive(re, im, k, inv, ok, t);
    if (ok) push(model(re, im, k, inv), re, im, k, inv, t);
  endtask

  task automatic send_const(input int re, input int im, input int k, input bit inv,
                            input int ere, input int eim, input bit esat);
    bit ok;
    int t;
    drive(re, im, k, inv, ok, t);
    if (ok) push({esat, DWO'(ere), DWO'(eim)}, re, im, k, inv, t);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // out_ready driver: pattern 1,0,0,1 repeating in backpressure mode
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // monitor: pop and compare on every output transfer
  initial begin
    logic [W-1:0] e;
    logic signed [DWO-1:0] er, ei;
    real ir, ii, d;
    int t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) chk("stable", {out_sat, dout_real, dout_imag}, held_val);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_out", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            ir = ire_q.pop_front();
            ii = iim_q.pop_front();
            t  = tin_q.pop_front();
            er = e[2*DWO-1:DWO];
            ei = e[DWO-1:0];
            chk("dout_real", dout_real, er);
            chk("dout_imag", dout_imag, ei);
            chk("out_sat", out_sat, e[W-1]);
            d = $itor(dout_real) - ir;
            chk("tol_real", (d <= 1.0 && d >= -1.0), 1);
            d = $itor(dout_imag) - ii;
            chk("tol_imag", (d <= 1.0 && d >= -1.0), 1);
            if (lat_en) chk("latency", cyc - t, 3);
          end
        end
        if (bp_mode) chk("in_ready", in_ready, !(out_valid && !out_ready));
        held     = out_valid && !out_ready;
        held_val = {out_sat, dout_real, dout_imag};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout_real", dout_real, 0);
    chk("rst_dout_imag", dout_imag, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // directed, bit-exact expectations
    send_const(100, -50, 0, 0, 100, -50, 0);
    send_const(100, -50, 16, 0, -50, -100, 0);
    send_const(100, -50, 16, 1, 50, 100, 0);
    send_const(511, 0, 8, 0, 361, -361, 0);
    send_const(511, 0, 24, 0, -361, -361, 0);
    send_const(511, 0, 8, 1, 361, 361, 0);
    send_const(100, -50, 32, 0, -100, 50, 0);
    send_const(100, -50, 48, 0, 50, 100, 0);
    send_const(-512, -512, 0, 1, -512, -512, 0);
    send_const(-512, 511, 32, 0, 512, -511, 0);
    wait_drain();

    // full sweep, both directions, random data
    for (int k = 0; k < N; k++) begin
      for (int inv = 0; inv < 2; inv++) begin
        send_model(int'($urandom_range(1023, 0)) - 512, int'($urandom_range(1023, 0)) - 512, k, inv[0]);
      end
    end
    wait_drain();

    // backpressure
    lat_en  = 1'b0;
    bp_cnt  = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_model(int'($urandom_range(1023, 0)) - 512, int'($urandom_range(1023, 0)) - 512,
                 int'($urandom_range(N - 1, 0)), 1'($urandom_range(1, 0)));
    end
    wait_drain();
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lat_en = 1'b1;

    // reset with three samples in flight
    send_model(200, 100, 5, 0);
    send_model(-300, 7, 40, 1);
    send_model(11, -400, 57, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    ire_q.delete();
    iim_q.delete();
    tin_q.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_dout_real", dout_real, 0);
    chk("flush_dout_imag", dout_imag, 0);
    chk("flush_out_sat", out_sat, 0);
    chk("flush_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // saturation on the narrow-output instance
    b_din_real = -512;
    b_din_imag = -512;
    b_tw_idx   = 6'd8;
    b_inverse  = 1'b0;
    b_in_valid = 1'b1;
    @(negedge clk);
    chk("b_in_ready", b_in_ready, 1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      got = b_out_valid;
      n++;
    end
    chk("b_out_valid", got, 1);
    chk("b_dout_real", b_dout_real, -512);
    chk("b_dout_imag", b_dout_imag, 0);
    chk("b_out_sat", b_out_sat, 1);
    @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dif_radix2_tm_param.md
Name: dif_radix2_tm_param

Overview:
Parametrised twiddle multiplier for radix-2 DIF FFT stages of any power-of-two size N = 2^LOG2N. It multiplies each complex sample by W_N^k = cos(2πk/N) − j·sin(2πk/N), or by the conjugate when `inverse` is set. The twiddle is taken from a one-octant ROM and extended to the full circle by octant folding and quadrant rotation. It sits between butterfly stages, uses a valid/ready handshake, and supports any N/word size and IFFT reuse.

Parameters:
DATA_WIDTH_IN, 10, signed input component width
DATA_WIDTH_OUT, DATA_WIDTH_IN+1, signed output component width; results are saturated to this width
TW_WIDTH, 12, signed twiddle width, Q1.(TW_WIDTH-1) format, 1.0 = 2^(TW_WIDTH-1)
LOG2N, 6, log2 of FFT size; legal values 3..12
TW_FILE, "tw_rom.hex", $readmemh image holding N/8+1 entries {cos,sin} for m=0..N/8, rounded to nearest

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
din_real  in  DATA_WIDTH_IN  signed real part
din_imag  in  DATA_WIDTH_IN  signed imaginary part
tw_idx  in  LOG2N  twiddle exponent k
inverse  in  1  per-sample select: 1 = multiply by conj(W_N^k)
out_valid  out  1  output valid
out_ready  in  1  downstream accepts the output
dout_real  out  DATA_WIDTH_OUT  signed real result
dout_imag  out  DATA_WIDTH_OUT  signed imaginary result
out_sat  out  1  saturation occurred on either component of this sample

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid, out_sat, dout_real, dout_imag and all stage-valid bits = 0. Reset mid-operation discards in-flight samples. in_ready = 1 in the cycle after reset.
- Handshake: a transfer occurs when valid && ready on the same edge. in_ready = !(out_valid && !out_ready).
- Stall behaviour: when in_ready = 0, all pipeline registers hold and the outputs stay stable. No sample is dropped or duplicated.
- Bubbles are not compressed; samples stay in order.
- Latency: 3 cycles from input transfer to out_valid, with no stall.
- S1 (index decode): q = k[LOG2N-1:LOG2N-2], r = k mod N/4.
  - If r ≤ N/8: addr = r, swap = 0.
  - Else: addr = N/4 − r, swap = 1.
  - Register ROM {c,s} (swapped when swap = 1), q, inverse, trivial = (r == 0), and the input sample.
- S2 (multiply): partial products re·c, im·s, im·c, re·s at full precision (DATA_WIDTH_IN+TW_WIDTH bits).
  - Forward: P = re·c + im·s, Q = im·c − re·s.
  - Inverse: P = re·c − im·s, Q = im·c + re·s.
  - If trivial: P = re<<(TW_WIDTH-1), Q = im<<(TW_WIDTH-1). This path is exact and the ROM is ignored.
- S3 (rotate, round, saturate):
  - Rotate (P,Q) by quadrant. Forward uses (−j)^q: q=0 → (P,Q); q=1 → (Q,−P); q=2 → (−P,−Q); q=3 → (−Q,P). Inverse uses (+j)^q, i.e. the negation moves to the other component.
  - Round by adding 2^(TW_WIDTH-2), then arithmetic shift right by TW_WIDTH-1 (round-half-up).
  - Saturate to [−2^(DATA_WIDTH_OUT-1), 2^(DATA_WIDTH_OUT-1)−1]. out_sat = 1 if either component clipped.
  - Internal width must cover negation of the most-negative value with no wrap.
- Output registers load only on an S3 advance.
- k = 0, N/4, N/2, 3N/4 are bit-exact: sign-extended swaps/negations of the input, no rounding error.

Test Plan:
- LOG2N=6, k=0, din=(100,−50), out_ready=1 → out (100,−50) 3 cycles after the transfer; out_sat=0.
- k=16, din=(100,−50): forward → (−50,−100); inverse → (50,100). Both bit-exact.
- k=8, din=(511,0), TW_WIDTH=12 (cos45 = 1448) → out (361,−361). k=24 with the same din, forward → (−361,−361).
- Full sweep k=0..63 on random data vs a double-precision model → |error| ≤ 1 LSB per component; octant/quadrant folding checked.
- DATA_WIDTH_OUT=10 override, k=8, din=(−512,−512) → dout_real = −512 (clipped), out_sat=1.
- Backpressure: stream 10 samples with out_ready toggling 1,0,0,1,… → in_ready drops while out_valid && !out_ready; all 10 outputs in order, no loss or duplication; outputs stable during the stall.
- Reset asserted with 3 samples in flight → next cycle out_valid=0, outputs 0; no stale sample appears after reset release.
